noc_traffic_monitor: RTL and testbench

Synthesizable, parametrised traffic monitor for the HNoC ejection side. It snoops every PE's ejection handshake and counts accepted packets against a programmable completion target. It measures per-packet latency from an embedded injection timestamp, checks routing correctness, and reports elapsed cycles for throughput calculation. It sits beside the HNoC top in the clk100 domain and replaces bench-only packet counting, so the same statistics are available on silicon.

---
 rtl/noc_traffic_monitor.sv | 241 ++++++++++++++++++++++++
 tb/tb_noc_traffic_monitor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_monitor.sv
// -----------------------------------------------------------------------------
// noc_traffic_monitor
//
// Purpose:
//   Snoops every PE ejection handshake of the HNoC and gathers per-run traffic
//   statistics on silicon: accepted packet count against a programmable
//   completion target, per-packet latency (sum and maximum) derived from an
//   injection timestamp carried in the payload, routing correctness of each
//   ejected flit, and cycles elapsed in the run for throughput calculation.
//
// Ports:
//   clk100        clock
//   rst           synchronous, active-high reset
//   i_start       one-cycle pulse arming a measurement run (ignored in RUN)
//   i_valid       ejection valid, bit k = PE k
//   i_ready       ejection ready, bit k = PE k
//   i_data        flattened flits, slice k = {dest[ADDR_WIDTH-1:0], payload}
//   o_timestamp   free-running cycle count used by PEs to stamp payloads
//   o_busy        high while a run is in progress
//   o_done        high once the completion target has been reached
//   o_total_pkts  accepted packets this run (saturating)
//   o_elapsed     cycles spent in RUN (saturating)
//   o_lat_sum     sum of packet latencies (saturating)
//   o_lat_max     largest packet latency
//   o_overrun     sticky: accepted packets exceeded the target
//   o_addr_err    sticky: a flit was ejected on the wrong channel
//   o_err_chan    lowest channel index of the first address error
// -----------------------------------------------------------------------------
module noc_traffic_monitor #(
  parameter int NUM_PE     = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_PE),
  parameter int PKT_LIMIT  = 100,
  parameter int TS_WIDTH   = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int LSUM_WIDTH = 48
) (
  input  logic                                     clk100,
  input  logic                                     rst,
  input  logic                                     i_start,
  input  logic [NUM_PE-1:0]                        i_valid,
  input  logic [NUM_PE-1:0]                        i_ready,
  input  logic [NUM_PE*(DATA_WIDTH+ADDR_WIDTH)-1:0] i_data,
  output logic [TS_WIDTH-1:0]                      o_timestamp,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic [CNT_WIDTH-1:0]                     o_total_pkts,
  output logic [CNT_WIDTH-1:0]                     o_elapsed,
  output logic [LSUM_WIDTH-1:0]                    o_lat_sum,
  output logic [TS_WIDTH-1:0]                      o_lat_max,
  output logic                                     o_overrun,
  output logic                                     o_addr_err,
  output logic [ADDR_WIDTH-1:0]                    o_err_chan
);

  localparam int SLICE_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int BEAT_W  = $clog2(NUM_PE + 1);
  localparam logic [CNT_WIDTH:0] TARGET_C = (CNT_WIDTH+1)'(NUM_PE * PKT_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  logic [TS_WIDTH-1:0]     ts_r;
  logic                    busy_r;
  logic                    done_r;
  logic [CNT_WIDTH-1:0]    total_r;
  logic [CNT_WIDTH-1:0]    elapsed_r;
  logic [LSUM_WIDTH-1:0]   lat_sum_r;
  logic [TS_WIDTH-1:0]     lat_max_r;
  logic                    overrun_r;
  logic                    addr_err_r;
  logic [ADDR_WIDTH-1:0]   err_chan_r;

  // Per-channel decode of the snooped handshake and flit.
  logic [NUM_PE-1:0]       acc_s;
  logic [TS_WIDTH-1:0]     lat_s  [NUM_PE];
  logic [ADDR_WIDTH-1:0]   dest_s [NUM_PE];

  // Per-cycle reductions over all channels.
  logic [BEAT_W-1:0]       beats_s;
  logic [LSUM_WIDTH-1:0]   lsum_cyc_s;
  logic [TS_WIDTH-1:0]     lmax_cyc_s;
  logic                    bad_s;
  logic [ADDR_WIDTH-1:0]   bad_chan_s;

  // One extra bit on each running total exposes the carry used to saturate.
  logic [CNT_WIDTH:0]      tot_wide_s;
  logic [CNT_WIDTH:0]      elap_wide_s;
  logic [LSUM_WIDTH:0]     lsum_wide_s;
  logic [CNT_WIDTH-1:0]    tot_sat_s;
  logic [CNT_WIDTH-1:0]    elap_sat_s;
  logic [LSUM_WIDTH-1:0]   lsum_sat_s;
  logic                    complete_s;
  logic                    over_s;
  logic                    any_beat_s;

  // Payload bits above the timestamp are not inspected; folded here so the
  // whole input bus is visibly consumed.
  logic                    unused_data_s;
  assign unused_data_s = ^i_data;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_chan
    assign acc_s[g]  = i_valid[g] & i_ready[g];
    assign dest_s[g] = i_data[g*SLICE_W + DATA_WIDTH +: ADDR_WIDTH];
    // Unsigned modular subtract handles timestamp wrap-around.
    assign lat_s[g]  = ts_r - i_data[g*SLICE_W +: TS_WIDTH];
  end

  // Reduce accepted beats: count, latency sum, latency max, lowest misrouted channel.
  always_comb begin
    beats_s    = '0;
    lsum_cyc_s = '0;
    lmax_cyc_s = '0;
    bad_s      = 1'b0;
    bad_chan_s = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (acc_s[k]) begin
        beats_s    = beats_s + BEAT_W'(1'b1);
        lsum_cyc_s = lsum_cyc_s + LSUM_WIDTH'(lat_s[k]);
        if (lat_s[k] > lmax_cyc_s) begin
          lmax_cyc_s = lat_s[k];
        end else begin
          lmax_cyc_s = lmax_cyc_s;
        end
        // Scanning upwards, only the first mismatch is kept.
        if (!bad_s && (dest_s[k] != ADDR_WIDTH'(k))) begin
          bad_s      = 1'b1;
          bad_chan_s = ADDR_WIDTH'(k);
        end else begin
          bad_s      = bad_s;
          bad_chan_s = bad_chan_s;
        end
      end else begin
        beats_s = beats_s;
      end
    end
  end

  // Saturating next values and completion/overshoot decisions.
  always_comb begin
    tot_wide_s  = {1'b0, total_r} + {{(CNT_WIDTH+1-BEAT_W){1'b0}}, beats_s};
    elap_wide_s = {1'b0, elapsed_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
    lsum_wide_s = {1'b0, lat_sum_r} + {1'b0, lsum_cyc_s};
    tot_sat_s   = tot_wide_s[CNT_WIDTH]   ? {CNT_WIDTH{1'b1}}  : tot_wide_s[CNT_WIDTH-1:0];
    elap_sat_s  = elap_wide_s[CNT_WIDTH]  ? {CNT_WIDTH{1'b1}}  : elap_wide_s[CNT_WIDTH-1:0];
    lsum_sat_s  = lsum_wide_s[LSUM_WIDTH] ? {LSUM_WIDTH{1'b1}} : lsum_wide_s[LSUM_WIDTH-1:0];
    // Compared on the unsaturated sum so a whole overshooting cycle is seen.
    complete_s  = (tot_wide_s >= TARGET_C);
    over_s      = (tot_wide_s > TARGET_C);
    any_beat_s  = |acc_s;
  end

  // Free-running timestamp, counting in every state.
  always_ff @(posedge clk100) begin
    if (rst) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_WIDTH'(1'b1);
    end
  end

  // Run control FSM together with all statistics registers.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      total_r    <= '0;
      elapsed_r  <= '0;
      lat_sum_r  <= '0;
      lat_max_r  <= '0;
      overrun_r  <= 1'b0;
      addr_err_r <= 1'b0;
      err_chan_r <= '0;
    end else if (i_start && (state_r != S_RUN)) begin
      state_r    <= S_RUN;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      total_r    <= '0;
      elapsed_r  <= '0;
      lat_sum_r  <= '0;
      lat_max_r  <= '0;
      overrun_r  <= 1'b0;
      addr_err_r <= 1'b0;
      err_chan_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_IDLE;
        end
        S_RUN: begin
          elapsed_r <= elap_sat_s;
          total_r   <= tot_sat_s;
          lat_sum_r <= lsum_sat_s;
          if (lmax_cyc_s > lat_max_r) begin
            lat_max_r <= lmax_cyc_s;
          end
          if (bad_s && !addr_err_r) begin
            addr_err_r <= 1'b1;
            err_chan_r <= bad_chan_s;
          end
          if (complete_s) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            if (over_s) begin
              overrun_r <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Statistics are frozen; any further ejection is an overrun.
          if (any_beat_s) begin
            overrun_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_timestamp  = ts_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_total_pkts = total_r;
  assign o_elapsed    = elapsed_r;
  assign o_lat_sum    = lat_sum_r;
  assign o_lat_max    = lat_max_r;
  assign o_overrun    = overrun_r;
  assign o_addr_err   = addr_err_r;
  assign o_err_chan   = err_chan_r;

endmodule

// File: tb/tb_noc_traffic_monitor.sv
// -----------------------------------------------------------------------------
// tb_noc_traffic_monitor
//
// Self-checking bench for noc_traffic_monitor (16 PEs, target 32 packets).
// A run-level behavioural model tracks the expected statistics from the
// accepted beats of each cycle; every output is compared one time unit after
// each rising edge. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_noc_traffic_monitor;

  localparam int NPE    = 16;
  localparam int DW     = 32;
  localparam int AW     = 4;
  localparam int PL     = 2;
  localparam int TSW    = 16;
  localparam int CW     = 32;
  localparam int LW     = 48;
  localparam int SW     = DW + AW;
  localparam int TARGET = NPE * PL;

  localparam int MD_IDLE = 0;
  localparam int MD_RUN  = 1;
  localparam int MD_DONE = 2;

  logic                clk100 = 1'b0;
  logic                rst;
  logic                i_start;
  logic [NPE-1:0]      i_valid;
  logic [NPE-1:0]      i_ready;
  logic [NPE*SW-1:0]   i_data;
  logic [TSW-1:0]      o_timestamp;
  logic                o_busy;
  logic                o_done;
  logic [CW-1:0]       o_total_pkts;
  logic [CW-1:0]       o_elapsed;
  logic [LW-1:0]       o_lat_sum;
  logic [TSW-1:0]      o_lat_max;
  logic                o_overrun;
  logic                o_addr_err;
  logic [AW-1:0]       o_err_chan;

  always #5 clk100 = ~clk100;

  noc_traffic_monitor #(
    .NUM_PE(NPE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_LIMIT(PL),
    .TS_WIDTH(TSW), .CNT_WIDTH(CW), .LSUM_WIDTH(LW)
  ) dut (
    .clk100(clk100), .rst(rst), .i_start(i_start),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_timestamp(o_timestamp), .o_busy(o_busy), .o_done(o_done),
    .o_total_pkts(o_total_pkts), .o_elapsed(o_elapsed),
    .o_lat_sum(o_lat_sum), .o_lat_max(o_lat_max),
    .o_overrun(o_overrun), .o_addr_err(o_addr_err), .o_err_chan(o_err_chan)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int     m_mode  = MD_IDLE;
  longint m_ts    = 0;
  longint m_total = 0;
  longint m_elap  = 0;
  longint m_lsum  = 0;
  longint m_lmax  = 0;
  bit     m_over  = 1'b0;
  bit     m_aerr  = 1'b0;
  longint m_chan  = 0;

  localparam longint CMAX = (longint'(1) << CW) - 1;
  localparam longint LMAX = (longint'(1) << LW) - 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    int n;
    longint csum, cmax, lat;
    int bad;
    logic [SW-1:0] sl;
    n = 0; csum = 0; cmax = 0; bad = -1;
    for (int k = 0; k < NPE; k++) begin
      if (i_valid[k] && i_ready[k]) begin
        sl   = i_data[k*SW +: SW];
        lat  = (m_ts - longint'(sl[TSW-1:0]) + 65536) % 65536;
        n++;
        csum += lat;
        if (lat > cmax) cmax = lat;
        if (bad < 0 && int'(sl[SW-1 -: AW]) != k) bad = k;
      end
    end
    if (rst) begin
      m_mode = MD_IDLE; m_ts = 0; m_total = 0; m_elap = 0; m_lsum = 0;
      m_lmax = 0; m_over = 0; m_aerr = 0; m_chan = 0;
    end else begin
      m_ts = (m_ts + 1) % 65536;
      if (i_start && m_mode != MD_RUN) begin
        m_mode = MD_RUN; m_total = 0; m_elap = 0; m_lsum = 0;
        m_lmax = 0; m_over = 0; m_aerr = 0; m_chan = 0;
      end else if (m_mode == MD_RUN) begin
        if (m_total + n >= TARGET) begin
          m_mode = MD_DONE;
          if (m_total + n > TARGET) m_over = 1;
        end
        m_elap  = (m_elap + 1 > CMAX) ? CMAX : m_elap + 1;
        m_total = (m_total + n > CMAX) ? CMAX : m_total + n;
        m_lsum  = (m_lsum + csum > LMAX) ? LMAX : m_lsum + csum;
        if (cmax > m_lmax) m_lmax = cmax;
        if (bad >= 0 && !m_aerr) begin
          m_aerr = 1; m_chan = bad;
        end
      end else if (m_mode == MD_DONE) begin
        if (n > 0) m_over = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("timestamp", longint'(o_timestamp),  m_ts);
    chk("busy",      longint'(o_busy),       longint'(m_mode == MD_RUN));
    chk("done",      longint'(o_done),       longint'(m_mode == MD_DONE));
    chk("total",     longint'(o_total_pkts), m_total);
    chk("elapsed",   longint'(o_elapsed),    m_elap);
    chk("lat_sum",   longint'(o_lat_sum),    m_lsum);
    chk("lat_max",   longint'(o_lat_max),    m_lmax);
    chk("overrun",   longint'(o_overrun),    longint'(m_over));
    chk("addr_err",  longint'(o_addr_err),   longint'(m_aerr));
    chk("err_chan",  longint'(o_err_chan),   m_chan);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk100);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    rst     = 1'b0;
    i_start = 1'b0;
    i_valid = '0;
    i_ready = '0;
    for (int k = 0; k < NPE; k++) i_data[k*SW +: SW] = {4'($urandom), 32'($urandom)};
  endtask

  task automatic set_flit(input int k, input int dest, input longint lat);
    longint tsv;
    tsv = (m_ts - lat + 65536) % 65536;
    i_data[k*SW +: SW] = {4'(dest), 16'($urandom), 16'(tsv)};
  endtask

  task automatic put(input int k, input int dest, input longint lat);
    set_flit(k, dest, lat);
    i_valid[k] = 1'b1;
    i_ready[k] = 1'b1;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    step();
    step();
    chk("rst_ts_lit",    longint'(o_timestamp), 0);
    chk("rst_total_lit", longint'(o_total_pkts), 0);
    chk("rst_busy_lit",  longint'(o_busy), 0);

    // Idle with random traffic: nothing counted, timestamp runs
    for (int c = 0; c < 10; c++) begin
      clear_in();
      i_valid = NPE'($urandom);
      i_ready = NPE'($urandom);
      step();
    end
    chk("idle_ts_lit",    longint'(o_timestamp), 10);
    chk("idle_total_lit", longint'(o_total_pkts), 0);
    chk("idle_lsum_lit",  longint'(o_lat_sum), 0);

    // Single-channel run: 32 beats on channel 3, latency 5 each
    clear_in();
    i_start = 1'b1;
    step();
    chk("start_busy_lit", longint'(o_busy), 1);
    for (int i = 0; i < TARGET; i++) begin
      clear_in();
      put(3, 3, 5);
      step();
      if (i == TARGET - 2) chk("single_not_done_lit", longint'(o_done), 0);
    end
    chk("single_total_lit", longint'(o_total_pkts), 32);
    chk("single_lsum_lit",  longint'(o_lat_sum), 160);
    chk("single_lmax_lit",  longint'(o_lat_max), 5);
    chk("single_done_lit",  longint'(o_done), 1);
    chk("single_busy_lit",  longint'(o_busy), 0);
    chk("single_elap_lit",  longint'(o_elapsed), 32);

    // Beat while DONE: overrun set, statistics frozen
    clear_in();
    put(0, 0, 1);
    step();
    chk("done_over_lit",  longint'(o_overrun), 1);
    chk("done_total_lit", longint'(o_total_pkts), 32);

    // Restart from DONE clears everything
    clear_in();
    i_start = 1'b1;
    step();
    chk("restart_busy_lit",  longint'(o_busy), 1);
    chk("restart_total_lit", longint'(o_total_pkts), 0);
    chk("restart_over_lit",  longint'(o_overrun), 0);

    // All 16 channels at once with latencies 1..16
    clear_in();
    for (int k = 0; k < NPE; k++) put(k, k, k + 1);
    step();
    chk("simul_total_lit", longint'(o_total_pkts), 16);
    chk("simul_lsum_lit",  longint'(o_lat_sum), 136);
    chk("simul_lmax_lit",  longint'(o_lat_max), 16);

    // Timestamp wrap: stamp 0xFFFE seen at timestamp 3
    clear_in();
    rst = 1'b1;
    step();
    clear_in();
    i_start = 1'b1;
    step();
    for (int c = 0; c < 8 && m_ts != 3; c++) begin
      clear_in();
      step();
    end
    chk("wrap_ts_lit", longint'(o_timestamp), 3);
    clear_in();
    i_data[0 +: SW] = {4'd0, 16'h1234, 16'hFFFE};
    i_valid[0] = 1'b1;
    i_ready[0] = 1'b1;
    step();
    chk("wrap_lsum_lit", longint'(o_lat_sum), 5);
    chk("wrap_lmax_lit", longint'(o_lat_max), 5);

    // Misroute on channels 2 and 5 in one cycle, then overshoot the target
    clear_in();
    rst = 1'b1;
    step();
    clear_in();
    i_start = 1'b1;
    step();
    clear_in();
    put(2, 7, 1);
    put(5, 7, 1);
    step();
    chk("mis_err_lit",  longint'(o_addr_err), 1);
    chk("mis_chan_lit", longint'(o_err_chan), 2);
    clear_in();
    put(1, 9, 1);
    step();
    chk("mis_chan_hold_lit", longint'(o_err_chan), 2);
    clear_in();
    for (int k = 0; k < NPE; k++) put(k, k, 2);
    step();
    clear_in();
    for (int k = 0; k < 12; k++) put(k, k, 2);
    step();
    chk("pre_total_lit", longint'(o_total_pkts), TARGET - 1);
    chk("pre_done_lit",  longint'(o_done), 0);
    clear_in();
    for (int k = 0; k < 3; k++) put(k, k, 2);
    step();
    chk("over_total_lit", longint'(o_total_pkts), TARGET + 2);
    chk("over_flag_lit",  longint'(o_overrun), 1);
    chk("over_done_lit",  longint'(o_done), 1);

    // Abort mid-run: i_start in RUN ignored, rst returns all outputs to 0
    clear_in();
    i_start = 1'b1;
    step();
    clear_in();
    put(4, 4, 7);
    step();
    clear_in();
    i_start = 1'b1;
    put(6, 6, 3);
    step();
    chk("ignored_start_total_lit", longint'(o_total_pkts), 2);
    clear_in();
    rst = 1'b1;
    put(1, 1, 1);
    step();
    chk("abort_busy_lit",  longint'(o_busy), 0);
    chk("abort_total_lit", longint'(o_total_pkts), 0);
    chk("abort_ts_lit",    longint'(o_timestamp), 0);
    chk("abort_elap_lit",  longint'(o_elapsed), 0);

    // Randomised traffic with occasional starts, misroutes and resets
    for (int c = 0; c < 2000; c++) begin
      clear_in();
      for (int k = 0; k < NPE; k++) begin
        set_flit(k,
                 ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, NPE - 1)) : k,
                 ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 65535))
                                             : longint'($urandom_range(0, 200)));
      end
      i_valid = NPE'($urandom);
      i_ready = NPE'($urandom) & NPE'($urandom);
      i_start = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
